// File: rtl/ara_eoc_monitor.sv
// End-of-computation monitor: watches per-channel tohost exit words
// and produces one registered pass/fail/timeout verdict.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i             start pulse, accepted only in IDLE
//   chan_en_i           channel enable mask, sampled at start
//   exit_i              flat exit words, channel c at [c*ExitWidth +: ExitWidth]
//   done_o              sticky verdict valid
//   pass_o/fail_o/timeout_o  verdict, exactly one set with done_o
//   fail_chan_o         lowest failing channel index
//   cycles_o            RUN cycles up to and including the decision cycle
//   exit_o              aggregated tohost word {code,1} once done
//   chan_done_o         latched per-channel exit flags
module ara_eoc_monitor #(
  parameter int unsigned NrChannels    = 4,
  parameter int unsigned ExitWidth     = 64,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [ExitWidth-2:0] TimeoutCode = 'hDEAD,
  parameter int unsigned CntWidth      = 64,
  localparam int unsigned FcW =
    (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [NrChannels-1:0]           chan_en_i,
  input  logic [NrChannels*ExitWidth-1:0] exit_i,
  output logic                            done_o,
  output logic                            pass_o,
  output logic                            fail_o,
  output logic                            timeout_o,
  output logic [FcW-1:0]                  fail_chan_o,
  output logic [CntWidth-1:0]             cycles_o,
  output logic [ExitWidth-1:0]            exit_o,
  output logic [NrChannels-1:0]           chan_done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic [ExitWidth-2:0] code_t;

  state_e state_q, state_d;

  logic [NrChannels-1:0] en_q;
  logic [NrChannels-1:0] chan_done_q;
  code_t                 code_q [NrChannels];
  logic [CntWidth-1:0]   cnt_q;

  logic                  done_q;
  logic                  pass_q;
  logic                  fail_q;
  logic                  tmo_q;
  logic [FcW-1:0]        fail_chan_q;
  logic [CntWidth-1:0]   cycles_q;
  logic [ExitWidth-1:0]  exit_q;

  logic [NrChannels-1:0] new_lat;
  logic [NrChannels-1:0] eff_done;
  code_t                 eff_code [NrChannels];
  logic                  fail_any;
  logic [FcW-1:0]        fail_idx;
  code_t                 fail_code;
  logic                  pass_any;
  logic                  tmo_hit;
  logic [CntWidth-1:0]   cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Effective state folds this cycle's first samples into the
  // latched ones; the descending scan leaves the lowest failing index.
  always_comb begin
    new_lat   = '0;
    eff_done  = '0;
    eff_code  = '{default: '0};
    fail_any  = 1'b0;
    fail_idx  = '0;
    fail_code = '0;
    for (int c = NrChannels - 1; c >= 0; c--) begin
      eff_code[c] = code_q[c];
      if (state_q == RUN && en_q[c] && !chan_done_q[c]
          && exit_i[c*ExitWidth]) begin
        new_lat[c]  = 1'b1;
        eff_code[c] = exit_i[c*ExitWidth+1 +: ExitWidth-1];
      end
      eff_done[c] = chan_done_q[c] | new_lat[c];
      if (eff_done[c] && eff_code[c] != '0) begin
        fail_any  = 1'b1;
        fail_idx  = FcW'(c);
        fail_code = eff_code[c];
      end
    end
  end

  assign pass_any = ((eff_done & en_q) == en_q);
  assign tmo_hit  = (TimeoutCycles != 0)
                 && (cnt_inc == CntWidth'(TimeoutCycles));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (fail_any || pass_any || tmo_hit) state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q        <= '0;
      chan_done_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      fail_chan_q <= '0;
      cycles_q    <= '0;
      exit_q      <= '0;
      for (int c = 0; c < NrChannels; c++) code_q[c] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            en_q        <= chan_en_i;
            cnt_q       <= '0;
            chan_done_q <= '0;
            for (int c = 0; c < NrChannels; c++) code_q[c] <= '0;
          end
        end
        RUN: begin
          cnt_q       <= cnt_inc;
          chan_done_q <= eff_done;
          for (int c = 0; c < NrChannels; c++) begin
            if (new_lat[c]) code_q[c] <= eff_code[c];
          end
          if (state_d == DONE) begin
            done_q   <= 1'b1;
            cycles_q <= cnt_inc;
            // fail > pass > timeout
            if (fail_any) begin
              fail_q      <= 1'b1;
              fail_chan_q <= fail_idx;
              exit_q      <= {fail_code, 1'b1};
            end else if (pass_any) begin
              pass_q <= 1'b1;
              exit_q <= ExitWidth'(1);
            end else begin
              tmo_q  <= 1'b1;
              exit_q <= {TimeoutCode, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = tmo_q;
  assign fail_chan_o = fail_chan_q;
  assign cycles_o    = cycles_q;
  assign exit_o      = exit_q;
  assign chan_done_o = chan_done_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Scoreboard bench for ara_eoc_monitor: stimulus queues expected
// verdicts, a monitor pops and compares on each rising done_o.
module tb_ara_eoc_monitor;

  localparam int NCH = 4;
  localparam int EW  = 64;
  localparam int CW  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [NCH-1:0]  chan_en;
  logic [NCH*EW-1:0] exit_w;
  logic            done, pass, fail, tmo;
  logic [1:0]      fail_chan;
  logic [CW-1:0]   cycles;
  logic [EW-1:0]   exit_word;
  logic [NCH-1:0]  chan_done;

  ara_eoc_monitor #(
    .NrChannels   (NCH),
    .ExitWidth    (EW),
    .TimeoutCycles(100),
    .CntWidth     (CW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .chan_en_i  (chan_en),
    .exit_i     (exit_w),
    .done_o     (done),
    .pass_o     (pass),
    .fail_o     (fail),
    .timeout_o  (tmo),
    .fail_chan_o(fail_chan),
    .cycles_o   (cycles),
    .exit_o     (exit_word),
    .chan_done_o(chan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           p, f, t;
    logic [1:0]     fc;
    logic [CW-1:0]  cyc;
    logic [EW-1:0]  ex;
    logic [NCH-1:0] cd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare on every rising edge of done_o.
  initial begin
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = q.pop_front();
          chk({e.name, "_pass"},  64'(pass),      64'(e.p));
          chk({e.name, "_fail"},  64'(fail),      64'(e.f));
          chk({e.name, "_tmo"},   64'(tmo),       64'(e.t));
          chk({e.name, "_fchan"}, 64'(fail_chan), 64'(e.fc));
          chk({e.name, "_cyc"},   64'(cycles),    64'(e.cyc));
          chk({e.name, "_exit"},  exit_word,      e.ex);
          chk({e.name, "_cdone"}, 64'(chan_done), 64'(e.cd));
        end
      end
      if (!done) seen = 1'b0;
    end
  end

  task automatic set_exit(int c, logic [EW-1:0] v);
    exit_w[c*EW +: EW] = v;
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_done"},  64'(done), 64'(0));
    chk({nm, "_flags"}, 64'({pass, fail, tmo, fail_chan}), 64'(0));
    chk({nm, "_cyc"},   64'(cycles), 64'(0));
    chk({nm, "_exit"},  exit_word, 64'(0));
    chk({nm, "_cdone"}, 64'(chan_done), 64'(0));
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    rst_n  = 1'b0;
    start  = 1'b0;
    exit_w = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_idle(nm);
  endtask

  // Leaves the bench at the negedge inside RUN cycle 1.
  task automatic do_start(logic [NCH-1:0] en);
    @(negedge clk);
    chan_en = en;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic goto(int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic push(string nm, logic p, logic f, logic t,
                      logic [1:0] fc, int cy, logic [EW-1:0] ex,
                      logic [NCH-1:0] cd);
    exp_t e;
    e.name = nm; e.p = p; e.f = f; e.t = t;
    e.fc = fc; e.cyc = CW'(cy); e.ex = ex; e.cd = cd;
    q.push_back(e);
  endtask

  task automatic drain(string nm, int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 64'(q.size()), 64'(0));
    q.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    chan_en = '0;
    exit_w  = '0;
    do_reset("reset");

    // exit activity before any start has no effect
    for (int c = 0; c < NCH; c++) set_exit(c, 64'd3);
    repeat (5) @(negedge clk);
    chk_idle("prestart");

    // all pass
    do_reset("r1");
    push("allpass", 1, 0, 0, 0, 9, 64'd1, 4'b1111);
    do_start(4'b1111);
    goto(3); set_exit(0, 64'd1);
    goto(5); set_exit(1, 64'd1); set_exit(2, 64'd1);
    goto(8);
    chk("allpass_early", 64'(done), 64'(0));
    goto(9); set_exit(3, 64'd1);
    drain("allpass", 20);

    // fail with tie: channel 1 is the lowest failing index
    do_reset("r2");
    push("failtie", 0, 1, 0, 2'd1, 4, 64'd7, 4'b0110);
    do_start(4'b1111);
    goto(4);
    set_exit(2, (64'd7 << 1) | 64'd1);
    set_exit(1, (64'd3 << 1) | 64'd1);
    drain("failtie", 20);

    // masking and sticky first sample
    do_reset("r3");
    push("mask", 1, 0, 0, 0, 6, 64'd1, 4'b0101);
    do_start(4'b0101);
    goto(2); set_exit(1, (64'd5 << 1) | 64'd1);
    goto(3); set_exit(0, 64'd1);
    goto(4); set_exit(0, (64'd9 << 1) | 64'd1);
    goto(6); set_exit(2, 64'd1);
    drain("mask", 20);

    // timeout
    do_reset("r4");
    push("timeout", 0, 0, 1, 0, 100, 64'h1BD5B, 4'b0000);
    do_start(4'b1111);
    drain("timeout", 200);

    // fail coinciding with timeout wins
    do_reset("r5");
    push("tmofail", 0, 1, 0, 2'd3, 100, 64'd5, 4'b1000);
    do_start(4'b1111);
    goto(100); set_exit(3, (64'd2 << 1) | 64'd1);
    drain("tmofail", 20);

    // empty mask passes in the first RUN cycle
    do_reset("r6");
    push("empty", 1, 0, 0, 0, 1, 64'd1, 4'b0000);
    do_start(4'b0000);
    drain("empty", 20);

    // reset mid-run discards latches and restarts the count
    do_reset("r7");
    do_start(4'b1111);
    goto(5); set_exit(0, 64'd1);
    goto(20);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    rst_n  = 1'b1;
    exit_w = '0;
    push("restart", 1, 0, 0, 0, 7, 64'd1, 4'b0011);
    do_start(4'b0011);
    goto(3); set_exit(1, 64'd1);
    goto(7); set_exit(0, 64'd1);
    drain("restart", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
